// File: rtl/rob_pkg.sv
// rob_pkg: shared types for the multi-port reorder buffer.
// Holds the instruction_type encodings and the per-entry status struct.
// Payload fields (destination, value, next_pc) are XLEN-wide. Packages cannot be
// parameterised, so the top module keeps those fields in separate arrays.
package rob_pkg;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        LOAD   = 2'd1,
        STORE  = 2'd2,
        BRANCH = 2'd3
    } instruction_type;

    typedef struct packed {
        logic            valid;
        logic            data_ready;
        logic            address_valid;
        logic            exception;
        instruction_type itype;
    } rob_entry_t;

endpackage

// File: rtl/multi_port_reorder_buffer_if.sv
// multi_port_reorder_buffer_if: bundles the ROB dispatch, writeback, flush, commit and status signals.
// master: the pipeline side. It drives dispatch, cdb, agu and flush, and observes commit and status.
// slave : the reorder buffer.
interface multi_port_reorder_buffer_if #(
    parameter int XLEN           = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int CDB_PORTS      = 2
);
    logic [DISPATCH_WIDTH-1:0]                dispatch_valid;
    logic [DISPATCH_WIDTH-1:0][1:0]           dispatch_type;
    logic [DISPATCH_WIDTH-1:0][XLEN-1:0]      dispatch_destination;
    logic [DISPATCH_WIDTH-1:0][XLEN-1:0]      dispatch_value;
    logic [DISPATCH_WIDTH-1:0]                dispatch_data_ready;
    logic [DISPATCH_WIDTH-1:0][XLEN-1:0]      dispatch_pc;
    logic                                     dispatch_ready;
    logic [DISPATCH_WIDTH-1:0][TAG_WIDTH-1:0] dispatch_tag;
    logic [CDB_PORTS-1:0]                     cdb_valid;
    logic [CDB_PORTS-1:0][XLEN-1:0]           cdb_data;
    logic [CDB_PORTS-1:0][TAG_WIDTH-1:0]      cdb_rob_tag;
    logic [CDB_PORTS-1:0]                     cdb_exception;
    logic                                     agu_address_valid;
    logic [TAG_WIDTH-1:0]                     agu_address_rob_tag;
    logic                                     flush_valid;
    logic [TAG_WIDTH-1:0]                     flush_tag;
    logic [COMMIT_WIDTH-1:0]                  commit_valid;
    logic [COMMIT_WIDTH-1:0][1:0]             commit_type;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]        commit_destination;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]        commit_value;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]        commit_next_pc;
    logic                                     exception_valid;
    logic [TAG_WIDTH-1:0]                     exception_tag;
    logic [TAG_WIDTH-1:0]                     head;
    logic [TAG_WIDTH-1:0]                     tail;
    logic [TAG_WIDTH:0]                       count;
    logic                                     full;
    logic                                     empty;

    modport master (
        output dispatch_valid, dispatch_type, dispatch_destination, dispatch_value,
               dispatch_data_ready, dispatch_pc, cdb_valid, cdb_data, cdb_rob_tag,
               cdb_exception, agu_address_valid, agu_address_rob_tag, flush_valid, flush_tag,
        input  dispatch_ready, dispatch_tag, commit_valid, commit_type, commit_destination,
               commit_value, commit_next_pc, exception_valid, exception_tag,
               head, tail, count, full, empty
    );

    modport slave (
        input  dispatch_valid, dispatch_type, dispatch_destination, dispatch_value,
               dispatch_data_ready, dispatch_pc, cdb_valid, cdb_data, cdb_rob_tag,
               cdb_exception, agu_address_valid, agu_address_rob_tag, flush_valid, flush_tag,
        output dispatch_ready, dispatch_tag, commit_valid, commit_type, commit_destination,
               commit_value, commit_next_pc, exception_valid, exception_tag,
               head, tail, count, full, empty
    );
endinterface

// File: rtl/rob_commit_select.sv
// rob_commit_select: turns a per-slot readiness vector into an in-order commit mask.
// ready: readiness of head+k. mask: bit k set only if slots 0..k are all ready.
module rob_commit_select #(
    parameter int COMMIT_WIDTH = 2
) (
    input  logic [COMMIT_WIDTH-1:0] ready,
    output logic [COMMIT_WIDTH-1:0] mask
);
    logic run;

    always_comb begin
        mask = '0;
        run  = 1'b1;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            run     = run & ready[k];
            mask[k] = run;
        end
    end
endmodule

// File: rtl/multi_port_reorder_buffer.sv
// multi_port_reorder_buffer: circular reorder buffer with multi-slot dispatch, multi-port CDB
// writeback, store-address tracking, tag-based flush and in-order multi-slot commit.
// Ports: clk, reset (synchronous, active-high), and bus (the slave modport of
// multi_port_reorder_buffer_if).
// Option: when ROB_CDB_BYPASS_EN is defined, a CDB write to a head-window entry can commit that
// entry in the same cycle and supplies its cdb_data as the commit value. Without the macro, an
// entry commits no earlier than the cycle after its CDB write.
module multi_port_reorder_buffer
    import rob_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int CDB_PORTS      = 2
) (
    input logic                        clk,
    input logic                        reset,
    multi_port_reorder_buffer_if.slave bus
);
    localparam int BUF_SIZE = 2 ** TAG_WIDTH;

    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [TAG_WIDTH:0]   cnt_t;

    rob_entry_t      ent         [BUF_SIZE];
    logic [XLEN-1:0] destination [BUF_SIZE];
    logic [XLEN-1:0] value       [BUF_SIZE];
    logic [XLEN-1:0] next_pc     [BUF_SIZE];
    tag_t            head_q;
    tag_t            tail_q;
    cnt_t            count_q;

    tag_t                              flush_off;
    logic [BUF_SIZE-1:0]               kill;
    tag_t                              win_tag [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]           win_dr;
    logic [COMMIT_WIDTH-1:0]           win_ex;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0] win_val;
    logic [COMMIT_WIDTH-1:0]           ready;
    logic [COMMIT_WIDTH-1:0]           commit_mask;
    cnt_t                              n_disp;
    cnt_t                              n_commit;

    rob_commit_select #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_select (
        .ready (ready),
        .mask  (commit_mask)
    );

    // Age is measured as the offset from head. An entry is squashed when it is no older than
    // flush_tag. This also stays correct when the buffer is full and tail equals head.
    always_comb begin
        flush_off = tag_t'(bus.flush_tag - head_q);
        for (int e = 0; e < BUF_SIZE; e++)
            kill[e] = bus.flush_valid && (tag_t'(tag_t'(e) - head_q) >= flush_off);
    end

    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            win_tag[k] = head_q + tag_t'(k);
            win_dr[k]  = ent[win_tag[k]].data_ready;
            win_ex[k]  = ent[win_tag[k]].exception;
            win_val[k] = value[win_tag[k]];
`ifdef ROB_CDB_BYPASS_EN
            // The loop walks from the highest port down, so the lowest matching port wins.
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (bus.cdb_valid[p] && bus.cdb_rob_tag[p] == win_tag[k]) begin
                    win_dr[k]  = 1'b1;
                    win_ex[k]  = ent[win_tag[k]].exception | bus.cdb_exception[p];
                    win_val[k] = bus.cdb_data[p];
                end
            end
`endif
            ready[k] = ent[win_tag[k]].valid && win_dr[k] && !win_ex[k]
                    && (ent[win_tag[k]].itype != STORE || ent[win_tag[k]].address_valid)
                    && !(bus.flush_valid && tag_t'(k) >= flush_off);
            bus.commit_type[k]        = ent[win_tag[k]].itype;
            bus.commit_destination[k] = destination[win_tag[k]];
            bus.commit_value[k]       = win_val[k];
            bus.commit_next_pc[k]     = next_pc[win_tag[k]];
        end
    end

    always_comb begin
        bus.dispatch_ready = (cnt_t'(BUF_SIZE) - count_q >= cnt_t'(DISPATCH_WIDTH)) && !bus.flush_valid;
        for (int i = 0; i < DISPATCH_WIDTH; i++)
            bus.dispatch_tag[i] = tail_q + tag_t'(i);
        n_disp   = bus.dispatch_ready ? cnt_t'($countones(bus.dispatch_valid)) : '0;
        n_commit = cnt_t'($countones(commit_mask));
    end

    assign bus.commit_valid    = commit_mask;
    assign bus.exception_valid = ent[head_q].valid && ent[head_q].exception;
    assign bus.exception_tag   = head_q;
    assign bus.head            = head_q;
    assign bus.tail            = tail_q;
    assign bus.count           = count_q;
    assign bus.full            = count_q == cnt_t'(BUF_SIZE);
    assign bus.empty           = count_q == '0;

    // The updates below are ordered so that later updates win. Commit and flush clears come
    // last, so a clear always overrides a CDB or AGU write to the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < BUF_SIZE; e++)
                ent[e] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (bus.dispatch_ready && bus.dispatch_valid[i]) begin
                    ent[tail_q + tag_t'(i)] <= '{valid: 1'b1,
                                                data_ready: bus.dispatch_data_ready[i],
                                                address_valid: 1'b0,
                                                exception: 1'b0,
                                                itype: instruction_type'(bus.dispatch_type[i])};
                    destination[tail_q + tag_t'(i)] <= bus.dispatch_destination[i];
                    value[tail_q + tag_t'(i)]       <= bus.dispatch_value[i];
                    next_pc[tail_q + tag_t'(i)]     <= bus.dispatch_pc[i] + XLEN'(4);
                end
            end
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (bus.cdb_valid[p] && ent[bus.cdb_rob_tag[p]].valid && !kill[bus.cdb_rob_tag[p]]) begin
                    ent[bus.cdb_rob_tag[p]].data_ready <= 1'b1;
                    ent[bus.cdb_rob_tag[p]].exception  <= ent[bus.cdb_rob_tag[p]].exception | bus.cdb_exception[p];
                    value[bus.cdb_rob_tag[p]]          <= bus.cdb_data[p];
                end
            end
            if (bus.agu_address_valid && ent[bus.agu_address_rob_tag].valid
                && ent[bus.agu_address_rob_tag].itype == STORE && !kill[bus.agu_address_rob_tag])
                ent[bus.agu_address_rob_tag].address_valid <= 1'b1;
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (commit_mask[k])
                    ent[win_tag[k]] <= '0;
            for (int e = 0; e < BUF_SIZE; e++)
                if (kill[e])
                    ent[e] <= '0;
            head_q  <= head_q + tag_t'(n_commit);
            tail_q  <= bus.flush_valid ? bus.flush_tag : tail_q + tag_t'(n_disp);
            count_q <= bus.flush_valid ? cnt_t'(tag_t'(bus.flush_tag - head_q - tag_t'(n_commit)))
                                       : count_q + n_disp - n_commit;
        end
    end
endmodule

// File: tb/tb_multi_port_reorder_buffer.sv
// tb_multi_port_reorder_buffer: directed self-checking bench for multi_port_reorder_buffer.
// Honours ROB_CDB_BYPASS_EN, so the same-cycle or next-cycle commit expectation follows the build.
module tb_multi_port_reorder_buffer;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    multi_port_reorder_buffer_if #(.XLEN(32), .TAG_WIDTH(4), .DISPATCH_WIDTH(2),
                                   .COMMIT_WIDTH(2), .CDB_PORTS(2)) bus ();

    multi_port_reorder_buffer #(.XLEN(32), .TAG_WIDTH(4), .DISPATCH_WIDTH(2),
                                .COMMIT_WIDTH(2), .CDB_PORTS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_valid       = '0;
        bus.dispatch_type        = '0;
        bus.dispatch_destination = '0;
        bus.dispatch_value       = '0;
        bus.dispatch_data_ready  = '0;
        bus.dispatch_pc          = '0;
        bus.cdb_valid            = '0;
        bus.cdb_data             = '0;
        bus.cdb_rob_tag          = '0;
        bus.cdb_exception        = '0;
        bus.agu_address_valid    = 1'b0;
        bus.agu_address_rob_tag  = '0;
        bus.flush_valid          = 1'b0;
        bus.flush_tag            = '0;
    endtask

    task automatic disp(input int i, input instruction_type ty, input logic [31:0] dst,
                        input logic [31:0] val, input logic [31:0] pc, input logic dr);
        bus.dispatch_valid[i]       = 1'b1;
        bus.dispatch_type[i]        = ty;
        bus.dispatch_destination[i] = dst;
        bus.dispatch_value[i]       = val;
        bus.dispatch_pc[i]          = pc;
        bus.dispatch_data_ready[i]  = dr;
    endtask

    task automatic cdb(input int p, input logic [3:0] tag, input logic [31:0] data, input logic exc);
        bus.cdb_valid[p]     = 1'b1;
        bus.cdb_rob_tag[p]   = tag;
        bus.cdb_data[p]      = data;
        bus.cdb_exception[p] = exc;
    endtask

    // The CDB inputs are already driven. With the bypass build the commit is visible in this
    // cycle. Without it, the commit is visible in the next cycle. Both paths end after the
    // commit edge.
    task automatic cdb_commit(input string tag, input logic [1:0] mask,
                              input logic [31:0] v0, input logic [31:0] v1);
        #1;
`ifdef ROB_CDB_BYPASS_EN
        check({tag, "_cv"}, 64'(bus.commit_valid), 64'(mask));
        check({tag, "_v0"}, 64'(bus.commit_value[0]), 64'(v0));
        if (mask[1]) check({tag, "_v1"}, 64'(bus.commit_value[1]), 64'(v1));
        tick();
        idle();
`else
        check({tag, "_pre_cv"}, 64'(bus.commit_valid), 64'(0));
        tick();
        idle();
        #1;
        check({tag, "_cv"}, 64'(bus.commit_valid), 64'(mask));
        check({tag, "_v0"}, 64'(bus.commit_value[0]), 64'(v0));
        if (mask[1]) check({tag, "_v1"}, 64'(bus.commit_value[1]), 64'(v1));
        tick();
`endif
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_head", 64'(bus.head), 64'(0));
        check("rst_tail", 64'(bus.tail), 64'(0));
        check("rst_count", 64'(bus.count), 64'(0));
        check("rst_empty", 64'(bus.empty), 64'(1));
        check("rst_full", 64'(bus.full), 64'(0));
        check("rst_dready", 64'(bus.dispatch_ready), 64'(1));
        check("rst_cv", 64'(bus.commit_valid), 64'(0));
        check("rst_exc", 64'(bus.exception_valid), 64'(0));

        // Dispatch ALU rd 10 and LOAD rd 8 in one cycle.
        disp(0, ALU, 32'd10, 32'd0, 32'h100, 1'b0);
        disp(1, LOAD, 32'd8, 32'd0, 32'h104, 1'b0);
        #1;
        check("d_tag0", 64'(bus.dispatch_tag[0]), 64'(0));
        check("d_tag1", 64'(bus.dispatch_tag[1]), 64'(1));
        tick();
        idle();
        #1;
        check("d_tail", 64'(bus.tail), 64'(2));
        check("d_count", 64'(bus.count), 64'(2));
        check("d_cv", 64'(bus.commit_valid), 64'(0));

        // Tag 1 completes first, so the in-order mask stays empty. Then tag 0 completes.
        cdb(0, 4'd1, 32'hAAAA_0001, 1'b0);
        #1;
        check("c1_cv", 64'(bus.commit_valid), 64'(0));
        tick();
        idle();
        cdb(1, 4'd0, 32'h7867_5645, 1'b0);
        cdb_commit("c2", 2'b11, 32'h7867_5645, 32'hAAAA_0001);
        #1;
        check("c2_head", 64'(bus.head), 64'(2));
        check("c2_empty", 64'(bus.empty), 64'(1));

        // A store waits for its address even when its data is ready.
        disp(0, STORE, 32'h40, 32'h55, 32'h200, 1'b1);
        tick();
        idle();
        #1;
        check("st_tail", 64'(bus.tail), 64'(3));
        check("st_cv0", 64'(bus.commit_valid), 64'(0));
        tick();
        check("st_cv1", 64'(bus.commit_valid), 64'(0));
        bus.agu_address_valid   = 1'b1;
        bus.agu_address_rob_tag = 4'd2;
        #1;
        check("st_cv_agu", 64'(bus.commit_valid), 64'(0));
        tick();
        idle();
        #1;
        check("st_cv", 64'(bus.commit_valid), 64'(1));
        check("st_type", 64'(bus.commit_type[0]), 64'(STORE));
        check("st_val", 64'(bus.commit_value[0]), 64'h55);
        check("st_dst", 64'(bus.commit_destination[0]), 64'h40);
        check("st_npc", 64'(bus.commit_next_pc[0]), 64'h204);
        tick();
        check("st_head", 64'(bus.head), 64'(3));
        check("st_empty", 64'(bus.empty), 64'(1));

        // Fill all 16 entries starting at tag 3. The tail wraps through 15 to 0.
        for (int j = 0; j < 8; j++) begin
            disp(0, ALU, 32'(j), 32'd0, 32'h300, 1'b0);
            disp(1, ALU, 32'(j), 32'd0, 32'h304, 1'b0);
            tick();
            idle();
            if (j == 6) begin
                #1;
                check("fill_tail_wrap", 64'(bus.tail), 64'(1));
                check("fill_dready14", 64'(bus.dispatch_ready), 64'(1));
            end
        end
        #1;
        check("fill_full", 64'(bus.full), 64'(1));
        check("fill_dready", 64'(bus.dispatch_ready), 64'(0));
        check("fill_count", 64'(bus.count), 64'(16));
        check("fill_tail", 64'(bus.tail), 64'(3));
        disp(0, ALU, 32'd1, 32'd0, 32'h0, 1'b1);
        disp(1, ALU, 32'd1, 32'd0, 32'h0, 1'b1);
        tick();
        idle();
        #1;
        check("extra_count", 64'(bus.count), 64'(16));
        check("extra_tail", 64'(bus.tail), 64'(3));
        cdb(0, 4'd3, 32'h3, 1'b0);
        cdb(1, 4'd4, 32'h4, 1'b0);
        tick();
        idle();
        tick();
        check("drain_head", 64'(bus.head), 64'(5));
        check("drain_count", 64'(bus.count), 64'(14));
        check("drain_dready", 64'(bus.dispatch_ready), 64'(1));
        check("drain_full", 64'(bus.full), 64'(0));

        // Set up a fresh buffer. Tags 0..3 commit at once and tags 4..9 stay pending.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            disp(0, ALU, 32'(2 * j), 32'd0, 32'h400, j < 2);
            disp(1, ALU, 32'(2 * j + 1), 32'd0, 32'h404, j < 2);
            tick();
            idle();
        end
        tick();
        tick();
        check("fl_head", 64'(bus.head), 64'(4));
        check("fl_tail", 64'(bus.tail), 64'(10));
        check("fl_count", 64'(bus.count), 64'(6));

        cdb(0, 4'd6, 32'h66, 1'b1);
        #1;
        check("fl_exc_nothead", 64'(bus.exception_valid), 64'(0));
        tick();
        idle();
        bus.flush_valid = 1'b1;
        bus.flush_tag   = 4'd6;
        cdb(0, 4'd7, 32'h77, 1'b0);
        #1;
        check("fl_dready", 64'(bus.dispatch_ready), 64'(0));
        tick();
        idle();
        #1;
        check("fl_tail6", 64'(bus.tail), 64'(6));
        check("fl_count2", 64'(bus.count), 64'(2));
        check("fl_head4", 64'(bus.head), 64'(4));

        disp(0, ALU, 32'd3, 32'd0, 32'h500, 1'b0);
        #1;
        check("re_tag", 64'(bus.dispatch_tag[0]), 64'(6));
        tick();
        idle();
        cdb(0, 4'd4, 32'hAAAA, 1'b0);
        cdb(1, 4'd4, 32'hBBBB, 1'b0);
        cdb_commit("tie", 2'b01, 32'hAAAA, 32'h0);
        cdb(0, 4'd5, 32'h55, 1'b0);
        cdb_commit("t5", 2'b01, 32'h55, 32'h0);
        #1;
        check("re_head", 64'(bus.head), 64'(6));
        check("re_exc_clean", 64'(bus.exception_valid), 64'(0));
        cdb(1, 4'd6, 32'h60, 1'b1);
        #1;
        check("ex_cv_now", 64'(bus.commit_valid), 64'(0));
        tick();
        idle();
        #1;
        check("ex_valid", 64'(bus.exception_valid), 64'(1));
        check("ex_tag", 64'(bus.exception_tag), 64'(6));
        check("ex_cv", 64'(bus.commit_valid), 64'(0));
        bus.flush_valid = 1'b1;
        bus.flush_tag   = 4'd6;
        tick();
        idle();
        #1;
        check("ex_fl_tail", 64'(bus.tail), 64'(6));
        check("ex_fl_empty", 64'(bus.empty), 64'(1));
        check("ex_fl_exc", 64'(bus.exception_valid), 64'(0));

        // Reset wins over a simultaneous flush and dispatch.
        disp(0, ALU, 32'd1, 32'd0, 32'h600, 1'b0);
        disp(1, ALU, 32'd2, 32'd0, 32'h604, 1'b0);
        tick();
        reset           = 1'b1;
        bus.flush_valid = 1'b1;
        bus.flush_tag   = 4'd7;
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("rf_head", 64'(bus.head), 64'(0));
        check("rf_tail", 64'(bus.tail), 64'(0));
        check("rf_count", 64'(bus.count), 64'(0));
        check("rf_dready", 64'(bus.dispatch_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_port_reorder_buffer.md
MULTI_PORT_REORDER_BUFFER -- requirements
Module: multi_port_reorder_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, ROB tag width; BUF_SIZE = 2**TAG_WIDTH entries.
REQ-003 SHALL have parameters DISPATCH_WIDTH (default 2), COMMIT_WIDTH (default 2) and CDB_PORTS (default 2), each 1..4.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 dispatch_valid  in  DISPATCH_WIDTH  allocate requests; set bits contiguous from bit 0.
REQ-007 dispatch_type / dispatch_destination / dispatch_value / dispatch_data_ready / dispatch_pc  in  DISPATCH_WIDTH x {2, XLEN, XLEN, 1, XLEN}  per-slot entry fields.
REQ-008 dispatch_ready  out  1  high when free entries >= DISPATCH_WIDTH and flush_valid low.
REQ-009 dispatch_tag  out  DISPATCH_WIDTH x TAG_WIDTH  tail+i, valid for slot i this cycle.
REQ-010 cdb_valid / cdb_data / cdb_rob_tag / cdb_exception  in  CDB_PORTS x {1, XLEN, TAG_WIDTH, 1}  writeback ports.
REQ-011 agu_address_valid / agu_address_rob_tag  in  1 / TAG_WIDTH  store address resolved.
REQ-012 flush_valid / flush_tag  in  1 / TAG_WIDTH  squash flush_tag and all younger entries.
REQ-013 commit_valid  out  COMMIT_WIDTH  in-order commit mask, contiguous from bit 0.
REQ-014 commit_type / commit_destination / commit_value / commit_next_pc  out  COMMIT_WIDTH x {2, XLEN, XLEN, XLEN}  head+i fields.
REQ-015 exception_valid / exception_tag  out  1 / TAG_WIDTH  head entry is complete with exception.
REQ-016 head, tail  out  TAG_WIDTH; count  out  TAG_WIDTH+1; full, empty  out  1.

Function
REQ-017 Dispatch: when dispatch_ready, each set dispatch_valid[i] writes entry tail+i (mod BUF_SIZE), valid=1, address_valid=0, exception=0, next_pc=dispatch_pc+4; tail advances by popcount(dispatch_valid) next cycle.
REQ-018 Dispatch with dispatch_ready low SHALL be ignored with no state change.
REQ-019 CDB: each cdb_valid[p] matching a valid entry sets data_ready, value=cdb_data, exception|=cdb_exception next cycle; writes to invalid entries ignored; equal tags on two ports: lowest port wins.
REQ-020 AGU: agu_address_valid on a valid STORE entry sets address_valid next cycle; otherwise ignored.
REQ-021 Entry i of the head window is committable when valid, data_ready, exception clear, and (type != STORE or address_valid).
REQ-022 commit_valid[k] SHALL be high combinationally iff entries head..head+k are all committable, k < COMMIT_WIDTH.
REQ-023 Committed entries SHALL be cleared and head advance by popcount(commit_valid) on the next edge.
REQ-024 Excepting entry SHALL block commit of itself and younger entries; exception_valid high only when it is at head.
REQ-025 Flush: entries from flush_tag to tail-1 invalidated, tail<=flush_tag next cycle; commits of entries older than flush_tag proceed same cycle; CDB/AGU writes to flushed entries dropped.
REQ-026 count = tail-head occupancy; next count = count + dispatched - committed (flush: recomputed from new tail); full when count==BUF_SIZE, empty when count==0.
REQ-027 Head/tail pointers SHALL wrap modulo BUF_SIZE with no bubble.

Reset
REQ-028 On reset: all valid/data_ready/address_valid/exception bits 0, head=tail=0, count=0, empty=1, full=0, commit_valid=0, exception_valid=0, dispatch_ready=1; dominates all other inputs, including mid-flush.

Configuration
REQ-029 Macro ROB_CDB_BYPASS_EN defined: a same-cycle CDB write to a head-window entry counts toward REQ-021, committing value cdb_data that cycle.
REQ-030 Macro undefined: entry is committable no earlier than the cycle after its CDB write.

Structure
REQ-031 Package rob_pkg SHALL hold the rob_entry_t struct and type constants, reusing the ALU/LOAD/STORE/BRANCH encodings from instruction_type.
REQ-032 Sub-module rob_commit_select SHALL compute the contiguous commit mask from a COMMIT_WIDTH-wide readiness vector.

Verification
REQ-033 Dispatch ALU(rd 10)+LOAD(rd 8) in one cycle -> tags 0,1, tail=2, count=2, commit_valid=0.
REQ-034 CDB ports drive tag 1 then tag 0 data 0x7867_5645 -> after both, commit_valid=2'b11, next cycle head=2, empty=1.
REQ-035 STORE at tag 2 with data ready, no AGU -> commit_valid=0; AGU tag 2 -> commit next cycle.
REQ-036 Fill to 16 entries -> full=1, dispatch_ready=0; extra dispatch ignored; commit 2 -> dispatch_ready=1; pointers wrap 15->0.
REQ-037 Entries 4..9, cdb_exception on tag 6, flush_tag=6 -> entries 6..9 invalid (valid mask 0x0030), tail=6; exception_valid once tag 6 reaches head before flush.
REQ-038 Same-cycle CDB write to head: commit_valid[0]=1 that cycle with ROB_CDB_BYPASS_EN, one cycle later without.
